// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory (combinational read).
// Optional request/conflict counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   cnt_gnt0,
  output logic [31:0]   cnt_gnt1,
  output logic [31:0]   cnt_conflict
`endif
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t              r_state;
  logic                r_owner;
  logic                r_we;
  logic [AW-1:0]       r_a;
  logic [DW-1:0]       r_wd;
  logic                r_last;
  logic [1:0]          r_rvalid;
  logic [1:0][DW-1:0]  r_rdata;

  logic w_pick0, w_gnt0, w_gnt1, w_any, w_access;

  // On conflict port 0 wins when fixed priority is set or port 1 won last time.
  assign w_pick0  = (FIXED_PRI != 0) || r_last;
  assign w_gnt0   = !reset && req0 && (!req1 || w_pick0);
  assign w_gnt1   = !reset && req1 && !(req0 && w_pick0);
  assign w_any    = w_gnt0 || w_gnt1;
  assign w_access = (r_state == S_ACCESS);

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign mem_we  = w_access && r_we && !reset;
  assign mem_a   = w_access ? r_a  : '0;
  assign mem_wd  = w_access ? r_wd : '0;
  assign rvalid0 = r_rvalid[0];
  assign rvalid1 = r_rvalid[1];
  assign rdata0  = r_rdata[0];
  assign rdata1  = r_rdata[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_a      <= '0;
      r_wd     <= '0;
      r_last   <= 1'b1;
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      // Response for the access closing at this edge; read-before-write data.
      r_rvalid <= w_access ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
      if (w_access)
        r_rdata[r_owner] <= mem_rd;
      if (w_any) begin
        r_state <= S_ACCESS;
        r_owner <= w_gnt1;
        r_we    <= w_gnt1 ? we1 : we0;
        r_a     <= w_gnt1 ? a1  : a0;
        r_wd    <= w_gnt1 ? wd1 : wd0;
        r_last  <= w_gnt1;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_gnt0     <= '0;
      cnt_gnt1     <= '0;
      cnt_conflict <= '0;
    end else begin
      if (w_gnt0)       cnt_gnt0     <= cnt_gnt0 + 32'd1;
      if (w_gnt1)       cnt_gnt1     <= cnt_gnt1 + 32'd1;
      if (req0 && req1) cnt_conflict <= cnt_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: the bench models dmem, a monitor checks responses.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] wd0, wd1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wd, mem_rd;
  logic [AW-1:0] mem_a;

  logic          fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_mem_we;
  logic [DW-1:0] fp_rdata0, fp_rdata1, fp_mem_wd;
  logic [DW-1:0] fp_rd = '0;
  logic [AW-1:0] fp_mem_a;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cnt_gnt0, cnt_gnt1, cnt_conflict;
  logic [31:0] fp_cnt_gnt0, fp_cnt_gnt1, fp_cnt_conflict;
`endif

  logic [31:0] ram [0:63];
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(0)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
    , .cnt_gnt0(cnt_gnt0), .cnt_gnt1(cnt_gnt1), .cnt_conflict(cnt_conflict)
`endif
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(1)) u_fp (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1), .gnt0(fp_gnt0), .gnt1(fp_gnt1),
    .rvalid0(fp_rvalid0), .rvalid1(fp_rvalid1), .rdata0(fp_rdata0), .rdata1(fp_rdata1),
    .mem_we(fp_mem_we), .mem_a(fp_mem_a), .mem_wd(fp_mem_wd), .mem_rd(fp_rd)
`ifdef DMEM_ARB_STATS_EN
    , .cnt_gnt0(fp_cnt_gnt0), .cnt_gnt1(fp_cnt_gnt1), .cnt_conflict(fp_cnt_conflict)
`endif
  );

  // dmem model: combinational read, write at the clock edge.
  assign mem_rd = ram[mem_a[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_a[7:2]] <= mem_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pops the oldest expected value for its port.
  always @(negedge clk) begin
    if (rvalid0 && rvalid1) chk("both_rvalid", 32'd1, 32'd0);
    if (rvalid0) begin
      if (exp0_q.size() == 0) chk("rvalid0_unexpected", 32'd1, 32'd0);
      else chk("rdata0_sb", rdata0, exp0_q.pop_front());
    end
    if (rvalid1) begin
      if (exp1_q.size() == 0) chk("rvalid1_unexpected", 32'd1, 32'd0);
      else chk("rdata1_sb", rdata1, exp1_q.pop_front());
    end
  end

  task automatic cyc(input logic r0, input logic w0, input logic [31:0] ad0, input logic [31:0] d0,
                     input logic r1, input logic w1, input logic [31:0] ad1, input logic [31:0] d1);
    @(negedge clk);
    req0 = r0; we0 = w0; a0 = ad0; wd0 = d0;
    req1 = r1; we1 = w1; a1 = ad1; wd1 = d1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t4_addr [0:2];
    logic [31:0] t4_data [0:2];
    logic [3:0]  rr_g0;
    t4_addr = '{32'h0, 32'h4, 32'h8};
    t4_data = '{32'h1000, 32'h1001, 32'h1234};
    rr_g0   = 4'b0101;
    for (int i = 0; i < 64; i++) ram[i] = 32'h1000 + i;
    ram[2] = 32'h1234;
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_a", mem_a, 0);
    reset = 1'b0;

    // Single load: gnt same cycle, access next, response after
    cyc(1, 0, 32'h8, 0, 0, 0, 0, 0);
    chk("t1_gnt0", gnt0, 1);
    chk("t1_gnt1", gnt1, 0);
    exp0_q.push_back(32'h1234);
    idle(1);
    chk("t1_mem_a", mem_a, 32'h8);
    chk("t1_mem_we", mem_we, 0);
    idle(1);
    chk("t1_rvalid0", rvalid0, 1);
    chk("t1_rdata0", rdata0, 32'h1234);
    idle(2);

    // Store then load of the same word: old data acked, new data read back
    cyc(0, 0, 0, 0, 1, 1, 32'h10, 32'hCAFE);
    chk("t2_gnt1", gnt1, 1);
    exp1_q.push_back(32'h1004);
    cyc(1, 0, 32'h10, 0, 0, 0, 0, 0);
    chk("t2_gnt0", gnt0, 1);
    chk("t2_mem_we", mem_we, 1);
    chk("t2_mem_wd", mem_wd, 32'hCAFE);
    exp0_q.push_back(32'hCAFE);
    idle(1);
    chk("t2_rvalid1", rvalid1, 1);
    chk("t2_rdata1", rdata1, 32'h1004);
    idle(1);
    chk("t2_rvalid0", rvalid0, 1);
    chk("t2_rdata1_hold", rdata1, 32'h1004);
    idle(2);

    // Conflicts after reset: round-robin 0,1,0,1 vs fixed 0,0,0,0
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
      chk("t3_rr_gnt0", gnt0, rr_g0[i]);
      chk("t3_rr_gnt1", gnt1, !rr_g0[i]);
      chk("t3_fp_gnt0", fp_gnt0, 1);
      chk("t3_fp_gnt1", fp_gnt1, 0);
      if (rr_g0[i]) exp0_q.push_back(32'h1000);
      else          exp1_q.push_back(32'h1001);
    end
    idle(3);

    // Back-to-back loads: 3 grants then 3 consecutive responses
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        cyc(1, 0, t4_addr[i], 0, 0, 0, 0, 0);
        exp0_q.push_back(t4_data[i]);
      end else begin
        idle(1);
      end
      chk("t4_gnt0", gnt0, (i < 3) ? 1 : 0);
      chk("t4_rvalid0", rvalid0, (i >= 2) ? 1 : 0);
    end
    idle(2);

    // Reset during a store access: write dropped, responses cleared
    cyc(1, 1, 32'h20, 32'hDEAD, 0, 0, 0, 0);
    chk("t5_gnt0", gnt0, 1);
    @(negedge clk);
    reset = 1'b1; req0 = 0; we0 = 0; req1 = 1;
    #1;
    chk("t5_mem_we", mem_we, 0);
    chk("t5_gnt1_rst", gnt1, 0);
    @(negedge clk);
    reset = 1'b0; req1 = 0;
    #1;
    chk("t5_rvalid0", rvalid0, 0);
    chk("t5_rvalid1", rvalid1, 0);
    chk("t5_rdata0", rdata0, 0);
    chk("t5_rdata1", rdata1, 0);
    chk("t5_idle_mem_a", mem_a, 0);
    chk("t5_ram8", ram[8], 32'h1008);

    // 3 conflicting cycles then a solo port-0 request
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 32'h0, 0, (i < 3), 0, 32'h4, 0);
      chk("t6_gnt0", gnt0, (i == 1) ? 0 : 1);
      if (i == 1) exp1_q.push_back(32'h1001);
      else        exp0_q.push_back(32'h1000);
    end
    idle(3);
`ifdef DMEM_ARB_STATS_EN
    chk("t6_cnt_conflict", cnt_conflict, 3);
    chk("t6_cnt_gnt0", cnt_gnt0, 3);
    chk("t6_cnt_gnt1", cnt_gnt1, 1);
`endif
    chk("sb0_drained", exp0_q.size(), 0);
    chk("sb1_drained", exp1_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
